spike_rate_meter: RTL and testbench

Downstream monitor for the LIF neuron's spike output. It counts spike rising edges over a programmable window of power-of-two cycles and reports the saturated count through a valid/ready handshake. It also measures the inter-spike interval (ISI) between consecutive spike edges. On the tile it consumes the neuron's 1-bit `spike` and provides a rate/ISI readout for the I/O pins or a later readout stage.

---
 rtl/spike_rate_meter.sv | 133 +++++++++++++
 tb/tb_spike_rate_meter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_meter.sv
// Spike rate and inter-spike interval monitor for a LIF neuron spike output.
// Counts spike rising edges per power-of-two window and measures edge-to-edge spacing.
module spike_rate_meter #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ISI_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             spike,
  input  logic [2:0]       win_sel,
  output logic [CNT_W-1:0] rate,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  output logic [ISI_W-1:0] isi,
  output logic             isi_valid
);

  localparam int unsigned WIN_W = 11;

  logic             spike_q;
  logic             en_q;
  logic             spk_edge;
  logic             en_rise;
  logic [2:0]       win_len;
  logic [2:0]       cur_len;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] win_last;
  logic             win_end;
  logic [CNT_W-1:0] spk_cnt;
  logic [CNT_W-1:0] spk_sum;
  logic             xfer;
  logic [ISI_W-1:0] isi_cnt;
  logic             seen;

  // On the cycle en rises the window length comes straight from win_sel,
  // so the first window is exactly L enabled cycles.
  always_comb begin
    spk_edge = spike & ~spike_q;
    en_rise  = en & ~en_q;
    cur_len  = en_rise ? win_sel : win_len;
    win_last = WIN_W'((32'd16 << cur_len) - 32'd1);
    win_end  = en & (win_cnt == win_last);
    xfer     = rate_valid & rate_ready;
    spk_sum  = spk_cnt;
    if (spk_edge && (spk_cnt != {CNT_W{1'b1}})) begin
      spk_sum = spk_cnt + CNT_W'(1);
    end
  end

  // Input history for edge and enable-rise detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      spike_q <= spike;
      en_q    <= en;
    end
  end

  // Window position and latched window length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      win_len <= '0;
    end else begin
      if (en_rise || win_end) begin
        win_len <= win_sel;
      end
      if (!en || win_end) begin
        win_cnt <= '0;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
      end
    end
  end

  // Saturating edge count within the current window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spk_cnt <= '0;
    end else if (!en || win_end) begin
      spk_cnt <= '0;
    end else begin
      spk_cnt <= spk_sum;
    end
  end

  // Result register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate       <= '0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (win_end) begin
      rate       <= spk_sum;
      rate_valid <= 1'b1;
      if (rate_valid && !rate_ready) begin
        overrun <= 1'b1;
      end
    end else if (xfer) begin
      rate_valid <= 1'b0;
    end
  end

  // Inter-spike interval: counter restarts at 1 on each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_cnt   <= '0;
      seen      <= 1'b0;
      isi       <= '0;
      isi_valid <= 1'b0;
    end else begin
      isi_valid <= 1'b0;
      if (!en) begin
        isi_cnt <= '0;
        seen    <= 1'b0;
      end else if (spk_edge) begin
        isi_cnt <= ISI_W'(1);
        seen    <= 1'b1;
        if (seen) begin
          isi       <= isi_cnt;
          isi_valid <= 1'b1;
        end
      end else if (isi_cnt != {ISI_W{1'b1}}) begin
        isi_cnt <= isi_cnt + ISI_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_meter.sv
// Directed self-checking bench for spike_rate_meter.
module tb_spike_rate_meter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        spike;
  logic [2:0]  win_sel;
  logic [7:0]  rate;
  logic        rate_valid;
  logic        rate_ready;
  logic        overrun;
  logic [11:0] isi;
  logic        isi_valid;

  int n_chk;
  int n_err;
  int pulses;

  spike_rate_meter #(.CNT_W(8), .ISI_W(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .spike      (spike),
    .win_sel    (win_sel),
    .rate       (rate),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .overrun    (overrun),
    .isi        (isi),
    .isi_valid  (isi_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disable_gap();
    en    = 1'b0;
    spike = 1'b0;
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    en = 1'b0;
    spike = 1'b0;
    win_sel = 3'd0;
    rate_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("reset_rate", 32'(rate), 0);
    chk("reset_valid", 32'(rate_valid), 0);
    chk("reset_overrun", 32'(overrun), 0);
    chk("reset_isi", 32'(isi), 0);
    chk("reset_isi_valid", 32'(isi_valid), 0);

    // Window count: L=16, spike every 4 cycles
    en = 1'b1;
    for (int c = 0; c < 48; c++) begin
      spike = (c % 4 == 0);
      tick();
      if (c % 16 == 15) begin
        chk("win_valid", 32'(rate_valid), 1);
        chk("win_rate", 32'(rate), 4);
        chk("win_overrun", 32'(overrun), 0);
      end else if (c % 16 == 0 && c > 0) begin
        chk("win_valid_drop", 32'(rate_valid), 0);
      end
    end
    disable_gap();

    // Saturation: L=2048, 1024 edges
    win_sel = 3'd7;
    en = 1'b1;
    for (int c = 0; c < 2048; c++) begin
      spike = (c % 2 == 0);
      tick();
      if (c == 2046) chk("sat_early", 32'(rate_valid), 0);
    end
    chk("sat_valid", 32'(rate_valid), 1);
    chk("sat_rate", 32'(rate), 255);
    disable_gap();

    // ISI: edges at 10, 17, 5000 after en rises
    win_sel = 3'd0;
    en = 1'b1;
    pulses = 0;
    for (int c = 0; c < 5002; c++) begin
      spike = (c == 10 || c == 17 || c == 5000);
      tick();
      if (isi_valid) pulses++;
      if (c == 10) chk("isi_first_none", 32'(isi_valid), 0);
      if (c == 17) begin
        chk("isi_second_valid", 32'(isi_valid), 1);
        chk("isi_second_val", 32'(isi), 7);
      end
      if (c == 18) chk("isi_pulse_width", 32'(isi_valid), 0);
      if (c == 5000) begin
        chk("isi_third_valid", 32'(isi_valid), 1);
        chk("isi_sat_val", 32'(isi), 4095);
      end
    end
    chk("isi_pulse_count", 32'(pulses), 2);
    disable_gap();

    // Level spike, mid-window win_sel change, en drop and restart
    for (int c = 0; c < 123; c++) begin
      en = !(c >= 85 && c <= 89);
      win_sel = (c >= 36) ? 3'd1 : 3'd0;
      spike = (c >= 2 && c <= 21) || c == 34 || c == 40 || c == 50 || c == 60 ||
              c == 70 || c == 82 || c == 87 || c == 95 || c == 100;
      tick();
      if (c == 15) chk("level_rate_w1", 32'(rate), 1);
      if (c == 31) chk("level_rate_w2", 32'(rate), 0);
      if (c == 47) begin
        chk("winsel_old_len_valid", 32'(rate_valid), 1);
        chk("winsel_old_len_rate", 32'(rate), 2);
      end
      if (c == 63) chk("winsel_no_16_end", 32'(rate_valid), 0);
      if (c == 79) begin
        chk("winsel_new_len_valid", 32'(rate_valid), 1);
        chk("winsel_new_len_rate", 32'(rate), 3);
      end
      if (c == 120) chk("restart_not_early", 32'(rate_valid), 0);
      if (c == 121) begin
        chk("restart_valid", 32'(rate_valid), 1);
        chk("restart_rate", 32'(rate), 2);
      end
    end
    disable_gap();

    // Overwrite and backpressure, then async reset mid-window
    win_sel = 3'd0;
    en = 1'b1;
    for (int c = 0; c < 51; c++) begin
      rate_ready = (c == 32);
      spike = (c == 0 || c == 2 || c == 4 || c == 16 || c == 18 || c == 20 ||
               c == 22 || c == 24 || c == 36);
      tick();
      if (c == 15) begin
        chk("ovr_w1_rate", 32'(rate), 3);
        chk("ovr_w1_overrun", 32'(overrun), 0);
      end
      if (c == 31) begin
        chk("ovr_w2_rate", 32'(rate), 5);
        chk("ovr_w2_valid", 32'(rate_valid), 1);
        chk("ovr_w2_overrun", 32'(overrun), 1);
      end
      if (c == 32) begin
        chk("ovr_xfer_valid", 32'(rate_valid), 0);
        chk("ovr_sticky", 32'(overrun), 1);
      end
      if (c == 47) begin
        chk("ovr_w3_valid", 32'(rate_valid), 1);
        chk("ovr_w3_rate", 32'(rate), 1);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rate", 32'(rate), 0);
    chk("async_rst_valid", 32'(rate_valid), 0);
    chk("async_rst_overrun", 32'(overrun), 0);
    chk("async_rst_isi", 32'(isi), 0);
    chk("async_rst_isi_valid", 32'(isi_valid), 0);
    en = 1'b0;
    spike = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Window end coinciding with a transfer
    en = 1'b1;
    for (int c = 0; c < 33; c++) begin
      rate_ready = (c == 31);
      spike = (c == 3 || c == 20 || c == 25);
      tick();
      if (c == 15) chk("simul_w1_rate", 32'(rate), 1);
      if (c == 31) begin
        chk("simul_rate", 32'(rate), 2);
        chk("simul_valid", 32'(rate_valid), 1);
        chk("simul_no_overrun", 32'(overrun), 0);
      end
      if (c == 32) chk("simul_valid_held", 32'(rate_valid), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
